arith_unwind: RTL and testbench
===============================

Name: arith_unwind

Overview:
- Reverse stepper for the x/y accumulation loop (forward step while selector && y<YMAX: x<=x+y, y<=y+1; reset state x=1, y=0).
- Loaded with a candidate final (x, y) pair; walks the sequence backwards one enabled step at a time until y reaches 0.
- Reports whether the pair is reachable from (1, 0).
- Sits downstream of the accumulator as a checker/decoder for captured state.

Parameters:
WIDTH, 15, bit width of x and y datapaths
YMAX, 200, largest y the forward loop can produce; larger y_in is rejected

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (rst==0 resets)
load  input  1  capture x_in/y_in; honoured in IDLE or DONE only
x_in  input  WIDTH  candidate final x
y_in  input  WIDTH  candidate final y
selector  input  1  step enable in RUN; low = stall, state held
x  output  WIDTH  current unwound x
y  output  WIDTH  current unwound y
busy  output  1  high in RUN
done  output  1  high in DONE (level, held until next load)
ok  output  1  valid while done; 1 = pair reachable from (1,0)
err_range  output  1  valid while done; y_in > YMAX
err_underflow  output  1  valid while done; backward subtraction would go negative

Behaviour:
- Reset (async, rst==0): state=IDLE, x=1, y=0, busy=0, done=0, ok=0, both err=0. Reset mid-RUN aborts immediately; no partial result is reported.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + load: x<=x_in, y<=y_in; all flags cleared.
  - If y_in > YMAX: next state DONE, err_range=1, ok=0.
  - Otherwise: next state RUN, busy=1.
- load during RUN is ignored.
- RUN, selector=0: x, y and state held.
- RUN, selector=1, y==0: DONE; ok = (x==1).
  - x != 1 gives ok=0 with both err flags 0 (inconsistent pair).
- RUN, selector=1, y!=0, with d = y-1 computed in WIDTH bits (no wrap, since y!=0):
  - If x < d: DONE, err_underflow=1, ok=0; x and y hold their pre-step values.
  - Else: x<=x-d, y<=d.
- Latency: a consistent pair completes after y_in+1 enabled RUN cycles; done rises on the edge of the final enabled cycle.
- Arithmetic: all unsigned WIDTH-bit; no subtraction is ever committed with a borrow.
- Flags are mutually exclusive; at most one of ok, err_range, err_underflow is high while done.
- Output defaults:
  - err_* and ok are 0 whenever done==0.
  - x, y retain their final values in DONE.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE};
  - WIDTH/YMAX defaults;
  - constants X_INIT=1, Y_INIT=0, shared with the forward accumulator.
- One natural sub-module: arith_unwind_step, a combinational function of (x, y) -> (x_next, y_next, at_origin, underflow).
- The FSM, registers and flags stay in the top module.

Test Plan:
- Load (4,3), selector=1 held -> x,y go (2,2),(1,1),(1,0); done=1, ok=1 after 4 enabled cycles.
- Load (19901,200), selector=1 -> done=1, ok=1 after 201 enabled cycles; busy high throughout.
- Load (2,3) -> (0,2), then underflow (0 < 1) -> done=1, err_underflow=1, x=0, y=2.
- Load (5,201) -> next cycle done=1, err_range=1, busy never asserted. Load (2,0) -> done=1, ok=0 after 1 enabled cycle.
- Load (4,3), toggle selector 1,0,0,1,1,1 -> x/y freeze on 0 cycles; still done with ok=1. A load pulsed mid-RUN has no effect.
- Load (19901,200), drop rst to 0 after 50 steps -> async x=1, y=0, done=0, IDLE. Reload (1,0) -> done, ok=1 after 1 enabled cycle.

Source files
------------

// File: rtl/arith_unwind_pkg.sv
// Shared types and constants for the x/y accumulation loop
// and its reverse stepper (state enum, datapath defaults, origin).
package arith_unwind_pkg;

  localparam int WIDTH_DEF = 15;
  localparam int YMAX_DEF  = 200;

  // Origin of the forward accumulator; shared with it.
  localparam int X_INIT = 1;
  localparam int Y_INIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/arith_unwind_step.sv
// One backward step of the accumulation loop (combinational).
// in: x, y   out: x_next, y_next, at_origin, underflow
module arith_unwind_step
  import arith_unwind_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x_next,
  output logic [WIDTH-1:0] y_next,
  output logic             at_origin,
  output logic             underflow
);

  logic [WIDTH-1:0] d;

  // Forward step added the old y (now y-1) to x.
  assign d         = y - WIDTH'(1);
  assign x_next    = x - d;
  assign y_next    = d;
  assign at_origin = (x == WIDTH'(X_INIT))
                   && (y == WIDTH'(Y_INIT));
  // Only meaningful when y != 0; d is then borrow-free.
  assign underflow = (y != WIDTH'(Y_INIT)) && (x < d);

endmodule

// File: rtl/arith_unwind.sv
// Reverse stepper: unwinds a captured (x, y) back to the origin.
// in: clk, rst, load, x_in, y_in, selector
// out: x, y, busy, done, ok, err_range, err_underflow
module arith_unwind
  import arith_unwind_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int YMAX  = YMAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             selector,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic             err_range,
  output logic             err_underflow
);

  localparam logic [WIDTH-1:0] YMAX_W = WIDTH'(YMAX);

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic             ok_r;
  logic             erng_r;
  logic             eund_r;

  logic [WIDTH-1:0] x_nxt;
  logic [WIDTH-1:0] y_nxt;
  logic             at_origin;
  logic             uflow;

  logic y_zero;
  logic range_bad;
  logic accept;
  logic stepping;

  arith_unwind_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .x        (x_r),
    .y        (y_r),
    .x_next   (x_nxt),
    .y_next   (y_nxt),
    .at_origin(at_origin),
    .underflow(uflow)
  );

  assign y_zero    = (y_r == WIDTH'(Y_INIT));
  assign range_bad = (y_in > YMAX_W);
  assign accept    = load && (state != RUN);
  assign stepping  = (state == RUN) && selector;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE,
      DONE: begin
        if (load) nxt = range_bad ? DONE : RUN;
      end
      RUN: begin
        if (selector && (y_zero || uflow))
          nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r    <= WIDTH'(X_INIT);
      y_r    <= WIDTH'(Y_INIT);
      ok_r   <= 1'b0;
      erng_r <= 1'b0;
      eund_r <= 1'b0;
    end else if (accept) begin
      x_r    <= x_in;
      y_r    <= y_in;
      ok_r   <= 1'b0;
      erng_r <= range_bad;
      eund_r <= 1'b0;
    end else if (stepping) begin
      if (y_zero) begin
        ok_r <= at_origin;
      end else if (uflow) begin
        // Keep the pre-step pair for inspection.
        eund_r <= 1'b1;
      end else begin
        x_r <= x_nxt;
        y_r <= y_nxt;
      end
    end
  end

  always_comb begin
    busy          = (state == RUN);
    done          = (state == DONE);
    ok            = done && ok_r;
    err_range     = done && erng_r;
    err_underflow = done && eund_r;
    x             = x_r;
    y             = y_r;
  end

endmodule

// File: tb/tb_arith_unwind.sv
// Directed bench for arith_unwind with a queue scoreboard:
// loads push expected final results, a monitor checks on done.
module tb_arith_unwind;

  localparam int W = 15;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ok;
    logic         er;
    logic         eu;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic         selector;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic         ok;
  logic         err_range;
  logic         err_underflow;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic done_q = 1'b0;

  arith_unwind dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .x_in         (x_in),
    .y_in         (y_in),
    .selector     (selector),
    .x            (x),
    .y            (y),
    .busy         (busy),
    .done         (done),
    .ok           (ok),
    .err_range    (err_range),
    .err_underflow(err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Monitor: on each rising done, pop and compare.
  always @(negedge clk) begin
    if (rst && done && !done_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got done want none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_x", int'(x), int'(mon_e.x));
        chk("sb_y", int'(y), int'(mon_e.y));
        chk("sb_ok", int'(ok), int'(mon_e.ok));
        chk("sb_erng", int'(err_range), int'(mon_e.er));
        chk("sb_eund", int'(err_underflow), int'(mon_e.eu));
      end
    end
    done_q = done;
  end

  task automatic do_load(input int xv, input int yv,
                         input int ex, input int ey,
                         input bit eok, input bit eer,
                         input bit eeu);
    exp_t e;
    e.x  = W'(ex);
    e.y  = W'(ey);
    e.ok = eok;
    e.er = eer;
    e.eu = eeu;
    exp_q.push_back(e);
    load     = 1'b1;
    x_in     = W'(xv);
    y_in     = W'(yv);
    selector = 1'b0;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Enabled cycles until done; busy must stay high before.
  task automatic run_done(input string nm,
                          input int exp_cyc);
    int cnt;
    int bz;
    cnt = 0;
    bz  = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) bz++;
      selector = 1'b1;
      @(posedge clk);
      #1;
      cnt++;
      if (done) break;
    end
    selector = 1'b0;
    chk({nm, "_cycles"}, cnt, exp_cyc);
    chk({nm, "_busy_low"}, bz, 0);
  endtask

  initial begin
    int sp[6];
    int ex[6];
    int ey[6];
    rst      = 1'b0;
    load     = 1'b0;
    x_in     = '0;
    y_in     = '0;
    selector = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", int'(x), 1);
    chk("rst_y", int'(y), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'({ok, err_range, err_underflow}), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Out-of-range y: straight to DONE, never busy.
    do_load(5, 201, 5, 201, 0, 1, 0);
    chk("rng_done", int'(done), 1);
    chk("rng_busy", int'(busy), 0);
    @(posedge clk);
    #1;

    // (4,3) stepping (2,2),(1,1),(1,0), then done.
    do_load(4, 3, 1, 0, 1, 0, 0);
    chk("p43_busy", int'(busy), 1);
    chk("p43_x0", int'(x), 4);
    ex = '{2, 1, 1, 1, 0, 0};
    ey = '{2, 1, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      selector = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("p43_x%0d", i + 1), int'(x), ex[i]);
      chk($sformatf("p43_y%0d", i + 1), int'(y), ey[i]);
      chk($sformatf("p43_done%0d", i + 1), int'(done),
          (i == 3) ? 1 : 0);
    end
    selector = 1'b0;

    // Longest legal pair.
    do_load(19901, 200, 1, 0, 1, 0, 0);
    run_done("p200", 201);

    // (2,3) -> (0,2) then underflow.
    do_load(2, 3, 0, 2, 0, 0, 1);
    run_done("uflow", 2);

    // Inconsistent pair at y==0.
    do_load(2, 0, 2, 0, 0, 0, 0);
    run_done("p20", 1);

    // Stalls plus an ignored mid-run load.
    do_load(4, 3, 1, 0, 1, 0, 0);
    sp = '{1, 0, 0, 1, 1, 1};
    ex = '{2, 2, 2, 1, 1, 1};
    ey = '{2, 2, 2, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      selector = sp[i][0];
      load     = (i == 1);
      x_in     = W'(7);
      y_in     = W'(4);
      @(posedge clk);
      #1;
      load = 1'b0;
      chk($sformatf("stall_x%0d", i), int'(x), ex[i]);
      chk($sformatf("stall_y%0d", i), int'(y), ey[i]);
      chk($sformatf("stall_done%0d", i), int'(done),
          (i == 5) ? 1 : 0);
    end
    selector = 1'b0;

    // Asynchronous abort mid-run.
    do_load(19901, 200, 0, 0, 0, 0, 0);
    void'(exp_q.pop_back());
    for (int i = 0; i < 50; i++) begin
      selector = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("ab_y50", int'(y), 150);
    #2;
    rst = 1'b0;
    #1;
    chk("ab_x", int'(x), 1);
    chk("ab_y", int'(y), 0);
    chk("ab_done", int'(done), 0);
    chk("ab_busy", int'(busy), 0);
    selector = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_load(1, 0, 1, 0, 1, 0, 0);
    run_done("p10", 1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
